iz_neuron_scheduler: RTL and testbench
======================================

# iz_neuron_scheduler

Time-multiplexing sequencer that shares one Izhikevich update datapath among N_NEURONS virtual neurons. It holds per-neuron membrane state (v, u) and stimulus in local registers. On each simulation tick it walks all neurons in index order, issues each one to the datapath with a start/done handshake, and writes the results back. It sits between the parameter loader (gated by `params_ready`) and a single shared update datapath, and publishes a per-sweep spike vector.

## Interface
Parameters:
- `N_NEURONS`, 4: number of virtual neurons, 2..16.
- `IDX_W`, 4: index width, must satisfy 2^IDX_W >= N_NEURONS.
- `V_INIT`, 16'hBF00: reset value of every v (Q8.8, -65.0).
- `U_INIT`, 16'hF300: reset value of every u (Q8.8, -13.0).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `enable` in 1: permits new sweeps to start.
- `params_ready` in 1: loader has valid a/b/c/d; sweeps start only while high.
- `tick` in 1: one-cycle pulse requesting a sweep.
- `stim_we` in 1: stimulus register write strobe.
- `stim_sel` in IDX_W: stimulus register index.
- `stim_in` in 8: stimulus value written.
- `clear_ovr` in 1: clears `overrun`.
- `dp_start` out 1: one-cycle datapath launch.
- `dp_idx` out IDX_W: neuron index under update.
- `dp_v` out 16: current v of `dp_idx`.
- `dp_u` out 16: current u of `dp_idx`.
- `dp_stim` out 8: stimulus of `dp_idx`.
- `dp_done` in 1: datapath result valid.
- `dp_v_next` in 16: updated v.
- `dp_u_next` in 16: updated u.
- `dp_spike` in 1: spike flag for this update.
- `busy` out 1: sweep in progress.
- `sweep_done` out 1: one-cycle pulse at end of sweep.
- `spike_vec` out N_NEURONS: spike flags of the last completed sweep, bit i = neuron i.
- `overrun` out 1: sticky, set when a tick was dropped.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, WB.
- IDLE: on `tick & enable & params_ready`, set idx=0, clear the spike accumulator, go to ISSUE. A tick is ignored without setting `overrun` if `enable` or `params_ready` is low.
- ISSUE: `dp_start`=1 for exactly one cycle, then go to WAIT. `dp_v`/`dp_u`/`dp_stim`/`dp_idx` are registered-state reads and stay stable from ISSUE through WB.
- WAIT: hold until `dp_done`=1, then capture `dp_v_next`, `dp_u_next` and `dp_spike`, and go to WB. `dp_done` outside WAIT is ignored.
- WB: write v[idx], u[idx] and acc[idx]=spike.
  - If idx==N_NEURONS-1: go to IDLE and, on the same edge, load `spike_vec` from acc (including this write) and pulse `sweep_done`.
  - Otherwise: idx+1 and go to ISSUE.
- `busy`=1 in ISSUE, WAIT and WB.
- A tick while `busy`=1 sets `overrun` and is dropped; the sweep continues unaffected. `clear_ovr` clears it; simultaneous set and clear leaves it set.
- Lowering `enable` or `params_ready` mid-sweep does not abort the sweep; it only blocks the next one.
- `stim_we` writes stim[stim_sel] at any time. If stim_sel >= N_NEURONS the write is ignored. A write to the neuron in ISSUE that same cycle is not seen by that update; `dp_stim` shows the old value, because the stimulus is latched at ISSUE.
- No arithmetic in this block; v, u and stim are stored verbatim.

## Timing
- Reset values (async, while `reset`=0):
  - state=IDLE, idx=0.
  - all v=V_INIT, all u=U_INIT, all stim=0.
  - `spike_vec`=0, `overrun`=0, `dp_start`=0, `busy`=0, `sweep_done`=0.
  - `dp_v`=V_INIT, `dp_u`=U_INIT, `dp_stim`=0, `dp_idx`=0.
- Reset mid-sweep returns immediately to the reset state; an in-flight datapath result is discarded.
- Tick accepted at edge T: `dp_start` is high in cycle T+1.
- `dp_done` may be asserted no earlier than the cycle after `dp_start`. Per-neuron cost is 2+L cycles, where L = cycles from `dp_start` to `dp_done` (L>=1).
- Sweep length: with fixed L, `sweep_done` and the new `spike_vec` appear N_NEURONS*(2+L) cycles after `dp_start` of neuron 0 rises, and `busy` falls in the same cycle.
- A tick arriving in the same cycle that `sweep_done` is high is accepted, because the state is IDLE.

## Test plan
- **Reset and basic sweep:** after reset, check the outputs match the reset values. With N=4, datapath L=1 returning v_next=v+16'h0100, u_next=u, spike=0, a single tick yields dp_idx 0,1,2,3, a sweep of 12 cycles, sweep_done once, and all v=16'hC000.
- **Spike capture:** the datapath spikes only on idx 2 -> spike_vec=4'b0100. The next sweep, with no spikes, gives spike_vec=4'b0000.
- **Overrun:** tick during WAIT of idx 1 -> overrun=1 and no extra sweep. clear_ovr -> 0. clear_ovr together with a new busy tick -> stays 1.
- **Gating:** a tick with params_ready=0 gives no dp_start and overrun=0. Dropping enable during idx 1 -> the sweep still completes all 4 neurons.
- **Stimulus:** write stim[3]=8'h5A before the tick -> dp_stim=8'h5A at idx 3. A write to sel 7 with N=4 is ignored. A write to idx 0 in its ISSUE cycle -> old value is shown.
- **Variable latency and reset:** random L of 1..5 per neuron gives the correct write-back order. Asserting reset during WAIT of idx 2 restores V_INIT/U_INIT everywhere, and a late dp_done is ignored.

Source files
------------

// File: rtl/iz_neuron_scheduler_if.sv
// Scheduler-side bundle: sweep control, stimulus writes, datapath handshake and status.
// master = scheduler, slave = loader/datapath/host environment.
interface iz_neuron_scheduler_if #(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 4
);
    logic                   enable;
    logic                   params_ready;
    logic                   tick;
    logic                   stim_we;
    logic [IDX_W-1:0]       stim_sel;
    logic [7:0]             stim_in;
    logic                   clear_ovr;
    logic                   dp_start;
    logic [IDX_W-1:0]       dp_idx;
    logic signed [15:0]     dp_v;
    logic signed [15:0]     dp_u;
    logic [7:0]             dp_stim;
    logic                   dp_done;
    logic signed [15:0]     dp_v_next;
    logic signed [15:0]     dp_u_next;
    logic                   dp_spike;
    logic                   busy;
    logic                   sweep_done;
    logic [N_NEURONS-1:0]   spike_vec;
    logic                   overrun;

    modport master (
        input  enable, params_ready, tick, stim_we, stim_sel, stim_in, clear_ovr,
        input  dp_done, dp_v_next, dp_u_next, dp_spike,
        output dp_start, dp_idx, dp_v, dp_u, dp_stim,
        output busy, sweep_done, spike_vec, overrun
    );

    modport slave (
        output enable, params_ready, tick, stim_we, stim_sel, stim_in, clear_ovr,
        output dp_done, dp_v_next, dp_u_next, dp_spike,
        input  dp_start, dp_idx, dp_v, dp_u, dp_stim,
        input  busy, sweep_done, spike_vec, overrun
    );
endinterface

// File: rtl/iz_neuron_scheduler.sv
// Time-multiplexes one Izhikevich update datapath across N_NEURONS neurons,
// holding per-neuron v/u/stimulus and publishing a spike vector per sweep.
module iz_neuron_scheduler #(
    parameter int          N_NEURONS = 4,
    parameter int          IDX_W     = 4,
    parameter logic [15:0] V_INIT    = 16'hBF00,
    parameter logic [15:0] U_INIT    = 16'hF300
) (
    input logic                   clk,
    input logic                   reset,
    iz_neuron_scheduler_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;
    typedef logic signed [15:0] q88_t;

    state_t                       r_state, w_state_nxt;
    logic [IDX_W-1:0]             r_idx, w_idx_nxt;
    q88_t [N_NEURONS-1:0]         r_v, r_u;
    logic [N_NEURONS-1:0][7:0]    r_stim;
    logic [N_NEURONS-1:0]         r_acc, w_acc_wb, r_spike_vec;
    q88_t                         r_dp_v, r_dp_u, r_res_v, r_res_u;
    logic [7:0]                   r_dp_stim;
    logic                         r_res_spike, r_overrun, r_sweep_done;
    logic                         w_accept, w_load, w_capture, w_wb, w_last, w_busy;
    q88_t                         w_rd_v, w_rd_u;
    logic [7:0]                   w_rd_stim;

    assign w_busy    = (r_state != S_IDLE);
    assign w_last    = (r_idx == IDX_W'(N_NEURONS - 1));
    assign w_capture = (r_state == S_WAIT) && bus.dp_done;
    assign w_wb      = (r_state == S_WB);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.tick && bus.enable && bus.params_ready) begin
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (bus.dp_done) w_state_nxt = S_WB;
            S_WB: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_load      = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand snapshot for the neuron about to enter ISSUE; index compared rather
    // than used directly because the index range can exceed N_NEURONS.
    always_comb begin
        w_rd_v    = r_v[0];
        w_rd_u    = r_u[0];
        w_rd_stim = r_stim[0];
        w_acc_wb  = r_acc;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_rd_v    = r_v[i];
                w_rd_u    = r_u[i];
                w_rd_stim = r_stim[i];
            end
            if (r_idx == IDX_W'(i)) w_acc_wb[i] = r_res_spike;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_acc        <= '0;
            r_spike_vec  <= '0;
            r_overrun    <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_sweep_done <= w_wb && w_last;
            if (w_accept)          r_acc       <= '0;
            else if (w_wb)         r_acc       <= w_acc_wb;
            if (w_wb && w_last)    r_spike_vec <= w_acc_wb;
            // A dropped tick wins over a simultaneous clear.
            if (bus.tick && w_busy) r_overrun  <= 1'b1;
            else if (bus.clear_ovr) r_overrun  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v         <= {N_NEURONS{V_INIT}};
            r_u         <= {N_NEURONS{U_INIT}};
            r_stim      <= '0;
            r_dp_v      <= V_INIT;
            r_dp_u      <= U_INIT;
            r_dp_stim   <= '0;
            r_res_v     <= '0;
            r_res_u     <= '0;
            r_res_spike <= 1'b0;
        end else begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (bus.stim_we && bus.stim_sel == IDX_W'(i)) r_stim[i] <= bus.stim_in;
                if (w_wb && r_idx == IDX_W'(i)) begin
                    r_v[i] <= r_res_v;
                    r_u[i] <= r_res_u;
                end
            end
            if (w_load) begin
                r_dp_v    <= w_rd_v;
                r_dp_u    <= w_rd_u;
                r_dp_stim <= w_rd_stim;
            end
            if (w_capture) begin
                r_res_v     <= bus.dp_v_next;
                r_res_u     <= bus.dp_u_next;
                r_res_spike <= bus.dp_spike;
            end
        end
    end

    assign bus.dp_start   = (r_state == S_ISSUE);
    assign bus.dp_idx     = r_idx;
    assign bus.dp_v       = r_dp_v;
    assign bus.dp_u       = r_dp_u;
    assign bus.dp_stim    = r_dp_stim;
    assign bus.busy       = w_busy;
    assign bus.sweep_done = r_sweep_done;
    assign bus.spike_vec  = r_spike_vec;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_iz_neuron_scheduler.sv
// Directed bench for iz_neuron_scheduler with a behavioural datapath (v+1.0, u kept).
module tb_iz_neuron_scheduler;
    localparam int N = 4;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    iz_neuron_scheduler_if #(.N_NEURONS(N), .IDX_W(IW)) bus ();
    iz_neuron_scheduler #(.N_NEURONS(N), .IDX_W(IW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int lat_tab [16];
    int spike_idx = -1;
    int n_starts  = 0;
    logic [15:0] exp_v [N];
    logic [3:0]  log_idx [$];
    logic [15:0] log_v [$];
    logic [15:0] log_u [$];
    logic [7:0]  log_stim [$];

    // Datapath model: latency lat_tab[idx] cycles after dp_start, v_next=v+0x0100, u_next=u.
    initial begin : dp_model
        int cnt;
        logic [3:0]  cur_idx;
        logic [15:0] cur_v, cur_u;
        cnt = 0; cur_idx = '0; cur_v = '0; cur_u = '0;
        bus.dp_done = 1'b0; bus.dp_v_next = '0; bus.dp_u_next = '0; bus.dp_spike = 1'b0;
        forever begin
            @(negedge clk);
            bus.dp_done = 1'b0;
            if (bus.dp_start === 1'b1) n_starts++;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.dp_done   = 1'b1;
                    bus.dp_v_next = cur_v + 16'h0100;
                    bus.dp_u_next = cur_u;
                    bus.dp_spike  = (int'(cur_idx) == spike_idx);
                end
            end else if (bus.dp_start === 1'b1) begin
                cur_idx = bus.dp_idx; cur_v = bus.dp_v; cur_u = bus.dp_u;
                log_idx.push_back(cur_idx); log_v.push_back(cur_v);
                log_u.push_back(cur_u);     log_stim.push_back(bus.dp_stim);
                cnt = lat_tab[cur_idx];
            end
        end
    end

    task automatic set_lat(input int l);
        for (int i = 0; i < 16; i++) lat_tab[i] = l;
    endtask

    task automatic start_log();
        log_idx.delete(); log_v.delete(); log_u.delete(); log_stim.delete();
    endtask

    task automatic bump_exp();
        for (int i = 0; i < N; i++) exp_v[i] = exp_v[i] + 16'h0100;
    endtask

    task automatic pulse_tick();
        @(negedge clk); bus.tick = 1'b1;
        @(negedge clk); bus.tick = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.sweep_done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b1; bus.params_ready = 1'b1; bus.tick = 1'b0; bus.clear_ovr = 1'b0;
        bus.stim_we = 1'b0; bus.stim_sel = '0; bus.stim_in = '0;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({bus.dp_start, bus.busy, bus.sweep_done, bus.overrun} !== 4'b0000)
            $display("FAIL rst_ctrl got %b want 0000", {bus.dp_start, bus.busy, bus.sweep_done, bus.overrun}); else n_pass++;
        n_checks++; if (bus.spike_vec !== 4'b0000) $display("FAIL rst_spike_vec got %b want 0000", bus.spike_vec); else n_pass++;
        n_checks++; if (bus.dp_v !== 16'hBF00) $display("FAIL rst_dp_v got %h want bf00", bus.dp_v); else n_pass++;
        n_checks++; if (bus.dp_u !== 16'hF300) $display("FAIL rst_dp_u got %h want f300", bus.dp_u); else n_pass++;
        n_checks++; if ({bus.dp_stim, bus.dp_idx} !== 12'h000) $display("FAIL rst_stim_idx got %h want 000", {bus.dp_stim, bus.dp_idx}); else n_pass++;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_sweep();
        int n, s0;
        set_lat(1); spike_idx = -1; start_log(); s0 = n_starts;
        pulse_tick();
        n_checks++; if ({bus.dp_start, bus.dp_idx} !== 5'b1_0000) $display("FAIL basic_first_start got %b want 10000", {bus.dp_start, bus.dp_idx}); else n_pass++;
        wait_done(n);
        n_checks++; if (n != 12) $display("FAIL basic_sweep_len got %0d want 12", n); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (log_idx.size() != 4) $display("FAIL basic_issue_count got %0d want 4", log_idx.size()); else n_pass++;
        for (int i = 0; i < log_idx.size() && i < N; i++) begin
            n_checks++; if (log_idx[i] !== 4'(i) || log_v[i] !== exp_v[i])
                $display("FAIL basic_issue%0d got idx %0d v %h want idx %0d v %h", i, log_idx[i], log_v[i], i, exp_v[i]); else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (bus.sweep_done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", bus.sweep_done); else n_pass++;
        n_checks++; if (n_starts - s0 != 4) $display("FAIL basic_start_cycles got %0d want 4", n_starts - s0); else n_pass++;
        bump_exp();
    endtask

    task automatic test_spike_capture();
        int n;
        spike_idx = 2; start_log();
        pulse_tick(); wait_done(n);
        n_checks++; if (bus.spike_vec !== 4'b0100) $display("FAIL spike_vec got %b want 0100", bus.spike_vec); else n_pass++;
        for (int i = 0; i < log_v.size() && i < N; i++) begin
            n_checks++; if (log_v[i] !== exp_v[i]) $display("FAIL spike_wb_v%0d got %h want %h", i, log_v[i], exp_v[i]); else n_pass++;
        end
        bump_exp();
        // Tick in the sweep_done cycle: state is already IDLE, so it is accepted.
        spike_idx = -1; start_log();
        bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0;
        n_checks++; if (bus.dp_start !== 1'b1) $display("FAIL b2b_accept got %b want 1", bus.dp_start); else n_pass++;
        wait_done(n);
        n_checks++; if (bus.spike_vec !== 4'b0000) $display("FAIL spike_vec_clear got %b want 0000", bus.spike_vec); else n_pass++;
        n_checks++; if (bus.overrun !== 1'b0) $display("FAIL b2b_overrun got %b want 0", bus.overrun); else n_pass++;
        bump_exp();
    endtask

    task automatic test_overrun();
        int n, k, s0;
        set_lat(3); start_log(); s0 = n_starts;
        pulse_tick();
        k = 0;
        while (!(bus.dp_idx == 4'd1 && bus.busy && !bus.dp_start) && k < 100) begin @(negedge clk); k++; end
        n_checks++; if (k >= 100) $display("FAIL ovr_find_wait got timeout want idx1 WAIT"); else n_pass++;
        bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0;
        n_checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", bus.overrun); else n_pass++;
        wait_done(n);
        repeat (6) @(negedge clk);
        n_checks++; if (n_starts - s0 != 4 || bus.busy !== 1'b0)
            $display("FAIL ovr_no_extra_sweep got starts %0d busy %b want 4 0", n_starts - s0, bus.busy); else n_pass++;
        n_checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", bus.overrun); else n_pass++;
        bus.clear_ovr = 1'b1; @(negedge clk); bus.clear_ovr = 1'b0;
        n_checks++; if (bus.overrun !== 1'b0) $display("FAIL ovr_clear got %b want 0", bus.overrun); else n_pass++;
        bump_exp();
        pulse_tick();
        repeat (3) @(negedge clk);
        bus.tick = 1'b1; bus.clear_ovr = 1'b1;
        @(negedge clk); bus.tick = 1'b0; bus.clear_ovr = 1'b0;
        n_checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_set_beats_clear got %b want 1", bus.overrun); else n_pass++;
        wait_done(n);
        bus.clear_ovr = 1'b1; @(negedge clk); bus.clear_ovr = 1'b0;
        bump_exp();
    endtask

    task automatic test_gating();
        int n, k, s0;
        set_lat(1); bus.params_ready = 1'b0; s0 = n_starts;
        pulse_tick();
        n_checks++; if (bus.dp_start !== 1'b0) $display("FAIL gate_params_start got %b want 0", bus.dp_start); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if ({bus.busy, bus.overrun} !== 2'b00 || n_starts != s0)
            $display("FAIL gate_params_quiet got busy/ovr %b starts %0d want 00 0", {bus.busy, bus.overrun}, n_starts - s0); else n_pass++;
        bus.params_ready = 1'b1; start_log();
        pulse_tick();
        k = 0;
        while (bus.dp_idx != 4'd1 && k < 100) begin @(negedge clk); k++; end
        bus.enable = 1'b0;
        wait_done(n);
        n_checks++; if (log_idx.size() != 4 || n >= 400)
            $display("FAIL gate_enable_drop got issues %0d want 4", log_idx.size()); else n_pass++;
        bump_exp();
        @(negedge clk);
        pulse_tick();
        n_checks++; if (bus.dp_start !== 1'b0) $display("FAIL gate_enable_start got %b want 0", bus.dp_start); else n_pass++;
        bus.enable = 1'b1;
    endtask

    task automatic test_stimulus();
        int n;
        logic [7:0] want;
        @(negedge clk); bus.stim_we = 1'b1; bus.stim_sel = 4'd3; bus.stim_in = 8'h5A;
        @(negedge clk); bus.stim_sel = 4'd7; bus.stim_in = 8'hFF;
        @(negedge clk); bus.stim_we = 1'b0;
        start_log();
        pulse_tick();
        bus.stim_we = 1'b1; bus.stim_sel = 4'd0; bus.stim_in = 8'h33;
        @(negedge clk); bus.stim_we = 1'b0;
        n_checks++; if (bus.dp_stim !== 8'h00) $display("FAIL stim_issue_write_hidden got %h want 00", bus.dp_stim); else n_pass++;
        wait_done(n);
        for (int i = 0; i < log_stim.size() && i < N; i++) begin
            want = (i == 3) ? 8'h5A : 8'h00;
            n_checks++; if (log_stim[i] !== want) $display("FAIL stim_sweep1_%0d got %h want %h", i, log_stim[i], want); else n_pass++;
        end
        bump_exp();
        start_log();
        pulse_tick(); wait_done(n);
        n_checks++; if (log_stim.size() != 4 || log_stim[0] !== 8'h33 || log_stim[3] !== 8'h5A)
            $display("FAIL stim_sweep2 got %0d entries s0 %h want 4 entries s0 33 s3 5a", log_stim.size(), log_stim[0]); else n_pass++;
        bump_exp();
    endtask

    task automatic test_latency_reset();
        int n, k, s0, sd;
        lat_tab[0] = 3; lat_tab[1] = 1; lat_tab[2] = 5; lat_tab[3] = 2;
        spike_idx = 2; start_log();
        pulse_tick(); wait_done(n);
        n_checks++; if (n != 19) $display("FAIL lat_sweep_len got %0d want 19", n); else n_pass++;
        n_checks++; if (bus.spike_vec !== 4'b0100) $display("FAIL lat_spike_vec got %b want 0100", bus.spike_vec); else n_pass++;
        for (int i = 0; i < log_idx.size() && i < N; i++) begin
            n_checks++; if (log_idx[i] !== 4'(i) || log_v[i] !== exp_v[i])
                $display("FAIL lat_issue%0d got idx %0d v %h want idx %0d v %h", i, log_idx[i], log_v[i], i, exp_v[i]); else n_pass++;
        end
        lat_tab[2] = 6; spike_idx = -1;
        pulse_tick();
        k = 0;
        while (!(bus.dp_idx == 4'd2 && bus.busy && !bus.dp_start) && k < 100) begin @(negedge clk); k++; end
        reset = 1'b0; #1;
        n_checks++; if ({bus.busy, bus.dp_start, bus.dp_idx, bus.spike_vec} !== 10'b0) $display("FAIL rst_mid_ctrl got %b want 0",
            {bus.busy, bus.dp_start, bus.dp_idx, bus.spike_vec}); else n_pass++;
        n_checks++; if (bus.dp_v !== 16'hBF00 || bus.dp_u !== 16'hF300 || bus.dp_stim !== 8'h00)
            $display("FAIL rst_mid_data got %h %h %h want bf00 f300 00", bus.dp_v, bus.dp_u, bus.dp_stim); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1; s0 = n_starts; sd = 0;
        repeat (10) begin @(negedge clk); if (bus.sweep_done === 1'b1) sd++; end
        n_checks++; if (bus.busy !== 1'b0 || sd != 0 || n_starts != s0)
            $display("FAIL rst_late_done got busy %b done %0d starts %0d want 0 0 0", bus.busy, sd, n_starts - s0); else n_pass++;
        set_lat(1); start_log();
        pulse_tick(); wait_done(n);
        n_checks++; if (log_v.size() != 4) $display("FAIL rst_sweep_count got %0d want 4", log_v.size()); else n_pass++;
        for (int i = 0; i < log_v.size() && i < N; i++) begin
            n_checks++; if (log_v[i] !== 16'hBF00 || log_u[i] !== 16'hF300 || log_stim[i] !== 8'h00)
                $display("FAIL rst_restored%0d got %h %h %h want bf00 f300 00", i, log_v[i], log_u[i], log_stim[i]); else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) exp_v[i] = 16'hBF00;
        set_lat(1);
        test_reset();
        test_basic_sweep();
        test_spike_capture();
        test_overrun();
        test_gating();
        test_stimulus();
        test_latency_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
